// File: rtl/alu_pkg.sv
// Shared definitions for the RV32I ALU: width, funct3 operation codes, bit-reverse helper.
package alu_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned SHAMT_W = 5;

    localparam logic [2:0] ALU_ADD  = 3'd0;
    localparam logic [2:0] ALU_SLL  = 3'd1;
    localparam logic [2:0] ALU_SLT  = 3'd2;
    localparam logic [2:0] ALU_SLTU = 3'd3;
    localparam logic [2:0] ALU_XOR  = 3'd4;
    localparam logic [2:0] ALU_SR   = 3'd5;
    localparam logic [2:0] ALU_OR   = 3'd6;
    localparam logic [2:0] ALU_AND  = 3'd7;

    function automatic logic [XLEN-1:0] bit_rev(input logic [XLEN-1:0] v);
        logic [XLEN-1:0] r;
        r = '0;
        for (int i = 0; i < int'(XLEN); i++) begin
            r[i] = v[XLEN-1-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/alu_shifter.sv
// Log barrel shifter; left shifts reuse the right-shift stages via bit reversal.
module alu_shifter
    import alu_pkg::*;
(
    input  logic [XLEN-1:0]    data_i,
    input  logic [SHAMT_W-1:0] shamt_i,
    input  logic               left_i,
    input  logic               arith_i,
    output logic [XLEN-1:0]    result_c
);

    logic            fill;
    logic [XLEN-1:0] s0, s1, s2, s3, s4, s5;

    // Sign fill only applies to arithmetic right shifts.
    assign fill = arith_i & ~left_i & data_i[XLEN-1];

    assign s0 = left_i ? bit_rev(data_i) : data_i;
    assign s1 = shamt_i[0] ? {fill, s0[XLEN-1:1]}         : s0;
    assign s2 = shamt_i[1] ? {{2{fill}}, s1[XLEN-1:2]}    : s1;
    assign s3 = shamt_i[2] ? {{4{fill}}, s2[XLEN-1:4]}    : s2;
    assign s4 = shamt_i[3] ? {{8{fill}}, s3[XLEN-1:8]}    : s3;
    assign s5 = shamt_i[4] ? {{16{fill}}, s4[XLEN-1:16]}  : s4;

    assign result_c = left_i ? bit_rev(s5) : s5;

endmodule

// File: rtl/rv32i_alu.sv
// RV32I execute-stage ALU: combinational operation select, result registered (1-cycle latency).
module rv32i_alu
    import alu_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] A,
    input  logic [XLEN-1:0] B,
    input  logic [2:0]      sel,
    input  logic            ext,
    output logic [XLEN-1:0] Y
);

    logic [XLEN-1:0] y_d, y_q;
    logic [XLEN-1:0] sum;
    logic [XLEN:0]   diff_s, diff_u;
    logic            lt_s, lt_u;
    logic [XLEN-1:0] shift_res;
    logic [XLEN-1:0] unused_diff;

    // ext selects subtract by inverting B and injecting a carry-in.
    assign sum = A + (ext ? ~B : B) + XLEN'(ext);

    // Dedicated 33-bit compares: the borrow out of the extended subtract is the less-than.
    assign diff_s = {A[XLEN-1], A} - {B[XLEN-1], B};
    assign diff_u = {1'b0, A} - {1'b0, B};
    assign lt_s   = diff_s[XLEN];
    assign lt_u   = diff_u[XLEN];
    assign unused_diff = diff_s[XLEN-1:0] ^ diff_u[XLEN-1:0];

    alu_shifter u_shifter (
        .data_i   (A),
        .shamt_i  (B[SHAMT_W-1:0]),
        .left_i   (sel == ALU_SLL),
        .arith_i  (ext),
        .result_c (shift_res)
    );

    always_comb begin
        y_d = '0;
        case (sel)
            ALU_ADD:  y_d = sum;
            ALU_SLL:  y_d = shift_res;
            ALU_SLT:  y_d = XLEN'(lt_s);
            ALU_SLTU: y_d = XLEN'(lt_u);
            ALU_XOR:  y_d = A ^ B;
            ALU_SR:   y_d = shift_res;
            ALU_OR:   y_d = A | B;
            ALU_AND:  y_d = A & B;
            default:  y_d = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            y_q <= '0;
        end else begin
            y_q <= y_d;
        end
    end

    assign Y = y_q;

endmodule

// File: tb/tb_rv32i_alu.sv
// Directed bench for rv32i_alu: hand-computed vectors checked one cycle after each drive.
module tb_rv32i_alu;

    logic        clk;
    logic        rst;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  sel;
    logic        ext;
    logic [31:0] y;

    int total = 0;
    int bad   = 0;

    rv32i_alu dut (
        .clk (clk),
        .rst (rst),
        .A   (a),
        .B   (b),
        .sel (sel),
        .ext (ext),
        .Y   (y)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] exp);
        total++;
        assert (y === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, y, exp);
        end
    endtask

    // Drive one operation, clock it in, then check the registered result.
    task automatic op(input string tag, input logic [31:0] av, input logic [31:0] bv,
                      input logic [2:0] s, input logic e, input logic [31:0] exp);
        a = av; b = bv; sel = s; ext = e;
        @(posedge clk); #1;
        check(tag, exp);
    endtask

    logic [31:0] lag_exp [8];
    logic [31:0] tog_exp [6];
    logic [2:0]  tog_sel [6];

    initial begin
        rst = 1'b1; a = 32'd10; b = 32'd5; sel = 3'd0; ext = 1'b0;
        @(posedge clk); #1;
        check("reset", 32'h0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("post_reset_add", 32'd15);

        op("add_neg",     32'd10,        32'hFFFF_FFFB, 3'd0, 1'b0, 32'd5);
        op("add_wrap",    32'hFFFF_FFFF, 32'd1,         3'd0, 1'b0, 32'h0);
        op("sub_10_5",    32'd10,        32'd5,         3'd0, 1'b1, 32'd5);
        op("sub_5_10",    32'd5,         32'd10,        3'd0, 1'b1, 32'hFFFF_FFFB);
        op("sub_0_10",    32'd0,         32'd10,        3'd0, 1'b1, 32'hFFFF_FFF6);

        op("sll_1",       32'd1,         32'd1,         3'd1, 1'b0, 32'd2);
        op("sll_31",      32'd1,         32'd31,        3'd1, 1'b0, 32'h8000_0000);
        op("sll_32",      32'd1,         32'd32,        3'd1, 1'b0, 32'd1);
        op("sll_0",       32'h1234_5678, 32'd0,         3'd1, 1'b0, 32'h1234_5678);
        op("sll_4",       32'h1234_5678, 32'd4,         3'd1, 1'b0, 32'h2345_6780);
        op("srl_31",      32'hFFFF_FFFF, 32'd31,        3'd5, 1'b0, 32'd1);
        op("srl_32",      32'hFFFF_FFFF, 32'd32,        3'd5, 1'b0, 32'hFFFF_FFFF);
        op("srl_4",       32'h8000_0000, 32'd4,         3'd5, 1'b0, 32'h0800_0000);
        op("sra_31",      32'hFFFF_FFFF, 32'd31,        3'd5, 1'b1, 32'hFFFF_FFFF);
        op("sra_10_1",    32'd10,        32'd1,         3'd5, 1'b1, 32'd5);
        op("sra_4",       32'h8000_0000, 32'd4,         3'd5, 1'b1, 32'hF800_0000);
        op("sra_0",       32'h8765_4321, 32'd0,         3'd5, 1'b1, 32'h8765_4321);

        op("slt_10_5",    32'd10,        32'd5,         3'd2, 1'b0, 32'd0);
        op("slt_5_10",    32'd5,         32'd10,        3'd2, 1'b0, 32'd1);
        op("slt_m1_0",    32'hFFFF_FFFF, 32'd0,         3'd2, 1'b0, 32'd1);
        op("slt_0_m1",    32'd0,         32'hFFFF_FFFF, 3'd2, 1'b0, 32'd0);
        op("slt_minmax",  32'h8000_0000, 32'h7FFF_FFFF, 3'd2, 1'b0, 32'd1);
        op("sltu_m1_0",   32'hFFFF_FFFF, 32'd0,         3'd3, 1'b0, 32'd0);
        op("sltu_0_m1",   32'd0,         32'hFFFF_FFFF, 3'd3, 1'b0, 32'd1);
        op("sltu_eq",     32'd7,         32'd7,         3'd3, 1'b0, 32'd0);

        op("xor_ff_aa",   32'hFFFF_FFFF, 32'hAAAA_AAAA, 3'd4, 1'b0, 32'h5555_5555);
        op("or_ff_aa",    32'hFFFF_FFFF, 32'hAAAA_AAAA, 3'd6, 1'b0, 32'hFFFF_FFFF);
        op("and_ff_aa",   32'hFFFF_FFFF, 32'hAAAA_AAAA, 3'd7, 1'b0, 32'hAAAA_AAAA);
        op("xor_10_5",    32'd10,        32'd5,         3'd4, 1'b0, 32'd15);
        op("or_10_5",     32'd10,        32'd5,         3'd6, 1'b0, 32'd15);
        op("and_10_5",    32'd10,        32'd5,         3'd7, 1'b0, 32'd0);

        // A=10, B=5, sel 0..7 back to back; Y must hold until the next edge.
        lag_exp = '{32'd15, 32'd320, 32'd0, 32'd0, 32'd15, 32'd0, 32'd15, 32'd0};
        a = 32'd10; b = 32'd5; ext = 1'b0;
        for (int i = 0; i < 8; i++) begin
            sel = 3'(i);
            @(posedge clk); #1;
            check($sformatf("lag_sel%0d", i), lag_exp[i]);
            sel = 3'(i + 1);
            #2;
            check($sformatf("lag_hold%0d", i), lag_exp[i]);
        end

        // ext must not affect sel 2,3,4,6,7,1.
        tog_sel = '{3'd2, 3'd3, 3'd4, 3'd6, 3'd7, 3'd1};
        tog_exp = '{32'd1, 32'd0, 32'hFFFF_FFF3, 32'hFFFF_FFF3, 32'd0, 32'hFFFF_FF80};
        for (int i = 0; i < 6; i++) begin
            op($sformatf("ext0_sel%0d", tog_sel[i]), 32'hFFFF_FFF0, 32'd3, tog_sel[i], 1'b0, tog_exp[i]);
            op($sformatf("ext1_sel%0d", tog_sel[i]), 32'hFFFF_FFF0, 32'd3, tog_sel[i], 1'b1, tog_exp[i]);
        end

        // Reset dominates a concurrent operation, and the operation is not replayed afterwards.
        op("pre_rst", 32'd100, 32'd23, 3'd0, 1'b0, 32'd123);
        rst = 1'b1;
        op("rst_wins", 32'd7, 32'd8, 3'd0, 1'b0, 32'h0);
        rst = 1'b0;
        op("after_rst", 32'd1, 32'd2, 3'd6, 1'b0, 32'd3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
